// File: rtl/hazard_forwarding_unit_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg: shared types and constants for the five-stage pipeline hazard
// logic.
//   REG_W          - register specifier width
//   R15            - PC register; reads of it never forward
//   fwd_sel_t      - operand select (FWD_RF / FWD_EX / FWD_MEM / FWD_WB)
//   stage_slot_t   - destination tracking for one of the EX, MEM and WB slots
//   slot_hit()     - slot writes the given register
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] R15 = 4'hF;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_EX  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b11;

    typedef struct packed {
        logic             valid_wr;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } stage_slot_t;

    function automatic logic slot_hit(input stage_slot_t slot, input logic [REG_W-1:0] src);
        return slot.valid_wr && (slot.rd == src);
    endfunction

endpackage

// File: rtl/hazard_forwarding_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_forwarding_unit_if: ID-stage request and hazard-control response
// bundle.
//   master (pipeline side): drives the id_* fields and branch_taken, and
//     receives the enables, the flush, the NOP select, the forward selects
//     and the counters.
//   slave (hazard unit side): the opposite directions.
// ---------------------------------------------------------------------------
interface hazard_forwarding_unit_if #(
    parameter int CNT_W = 16
);
    import pipe_pkg::*;

    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic [REG_W-1:0] id_rd;
    logic             id_use_rn;
    logic             id_use_rm;
    logic             id_use_rd;
    logic             id_rf_en;
    logic             id_load;
    logic             branch_taken;

    logic             pc_le;
    logic             ifid_le;
    logic             ifid_flush;
    logic             nop_sel;
    fwd_sel_t         fwd_a;
    fwd_sel_t         fwd_b;
    fwd_sel_t         fwd_c;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
               id_rf_en, id_load, branch_taken,
        input  pc_le, ifid_le, ifid_flush, nop_sel, fwd_a, fwd_b, fwd_c,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
               id_rf_en, id_load, branch_taken,
        output pc_le, ifid_le, ifid_flush, nop_sel, fwd_a, fwd_b, fwd_c,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_forwarding_unit_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard: EX -> MEM -> WB shift register of destination slots.
//   clk, reset          - pipeline clock, synchronous active-high reset
//   stall               - load-use stall this cycle; EX receives a bubble
//   id_rf_en, id_rd,
//   id_load             - destination info of the instruction leaving ID
//   ex_slot, mem_slot,
//   wb_slot             - registered slot contents
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             id_rf_en,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_load,
    output stage_slot_t      ex_slot,
    output stage_slot_t      mem_slot,
    output stage_slot_t      wb_slot
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else begin
            // The rd field is kept even for a bubble; valid_wr=0 masks it.
            ex_slot.valid_wr <= id_rf_en & ~stall;
            ex_slot.rd       <= id_rd;
            ex_slot.is_load  <= id_load & ~stall;
            mem_slot         <= ex_slot;
            wb_slot          <= mem_slot;
        end
    end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// ---------------------------------------------------------------------------
// hazard_forwarding_unit: forwarding selects, load-use stall and branch flush
// for the five-stage pipeline, plus saturating stall/flush counters.
//   clk, reset - pipeline clock, synchronous active-high reset
//   bus        - hazard_forwarding_unit_if.slave (ID fields in, controls out)
// ---------------------------------------------------------------------------
module hazard_forwarding_unit
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_forwarding_unit_if.slave bus
);

    stage_slot_t      ex_slot;
    stage_slot_t      mem_slot;
    stage_slot_t      wb_slot;
    logic             use_a;
    logic             use_b;
    logic             use_c;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    function automatic fwd_sel_t pick_fwd(input logic used, input logic [REG_W-1:0] src,
                                          input stage_slot_t ex, input stage_slot_t mem,
                                          input stage_slot_t wb);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (used) begin
            if (slot_hit(ex, src))       sel = FWD_EX;
            else if (slot_hit(mem, src)) sel = FWD_MEM;
            else if (slot_hit(wb, src))  sel = FWD_WB;
        end
        return sel;
    endfunction

    hazard_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .id_rf_en (bus.id_rf_en),
        .id_rd    (bus.id_rd),
        .id_load  (bus.id_load),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot)
    );

    // R15 is excluded at the source so it neither forwards nor stalls.
    assign use_a = bus.id_use_rn && (bus.id_rn != R15);
    assign use_b = bus.id_use_rm && (bus.id_rm != R15);
    assign use_c = bus.id_use_rd && (bus.id_rd != R15);

    // Masked in reset so a stall in flight does not leak into the counters.
    assign stall = ~reset && ex_slot.is_load &&
                   ((use_a && slot_hit(ex_slot, bus.id_rn)) ||
                    (use_b && slot_hit(ex_slot, bus.id_rm)) ||
                    (use_c && slot_hit(ex_slot, bus.id_rd)));

    assign flush = ~reset && ~stall && bus.branch_taken;

    always_comb begin
        bus.pc_le      = 1'b1;
        bus.ifid_le    = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.nop_sel    = 1'b0;
        bus.fwd_a      = FWD_RF;
        bus.fwd_b      = FWD_RF;
        bus.fwd_c      = FWD_RF;
        if (reset) begin
            bus.nop_sel = 1'b1;
        end else if (stall) begin
            bus.pc_le   = 1'b0;
            bus.ifid_le = 1'b0;
            bus.nop_sel = 1'b1;
        end else begin
            bus.ifid_flush = flush;
            bus.fwd_a      = pick_fwd(use_a, bus.id_rn, ex_slot, mem_slot, wb_slot);
            bus.fwd_b      = pick_fwd(use_b, bus.id_rm, ex_slot, mem_slot, wb_slot);
            bus.fwd_c      = pick_fwd(use_c, bus.id_rd, ex_slot, mem_slot, wb_slot);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_forwarding_unit.md
# hazard_forwarding_unit

Sequencing controller for the five-stage ARM pipeline (IF, ID, EX, MEM, WB). It tracks destination registers in flight through EX, MEM and WB, and from that state drives three groups of outputs:
- forwarding-mux selects for the three ID-stage operand reads;
- load-use stalls: PC enable, IF/ID enable and the `cuMux` NOP select;
- IF/ID flushes on taken branches.

It also keeps saturating stall and flush counters for simulation monitoring.

## Interface
Parameters:
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: pipeline clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `id_rn`, `id_rm`, `id_rd` in 4 each: register fields of the instruction in ID.
- `id_use_rn`, `id_use_rm`, `id_use_rd` in 1 each: the ID instruction reads that operand. `id_use_rd` covers the store data source.
- `id_rf_en` in 1: the ID instruction writes `id_rd`. Taken from the control unit, before `cuMux`.
- `id_load` in 1: the ID instruction is a load.
- `branch_taken` in 1: the branch resolved in ID is taken.
- `pc_le` out 1: PC load enable.
- `ifid_le` out 1: IF/ID load enable.
- `ifid_flush` out 1: clears IF/ID on the next edge.
- `nop_sel` out 1: 1 makes `cuMux` output all-zero control signals (bubble).
- `fwd_a`, `fwd_b`, `fwd_c` out 2 each: operand selects for Rn, Rm and Rd. 00 = register file, 01 = EX result, 10 = MEM result, 11 = WB result.
- `stall_cnt`, `flush_cnt` out `CNT_W` each.

## Operation
Internal scoreboard:
- Each of the three stage slots EX, MEM and WB holds {`valid_wr`, `rd[3:0]`, `is_load`}.
- Every cycle the slots shift EX→MEM→WB.
- The EX slot loads {`id_rf_en & ~stall`, `id_rd`, `id_load & ~stall`}. A stalled cycle therefore puts a bubble (`valid_wr=0`) into EX.

Forwarding (per operand X ∈ {a:Rn, b:Rm, c:Rd}), combinational:
- Condition: `id_use_X` is set, the source register is not R15, and a slot has `valid_wr` with a matching `rd`.
- Priority when several slots match: EX (01) > MEM (10) > WB (11). Otherwise the select is 00.
- R15 reads are never forwarded; the select is always 00.

Load-use stall:
- `stall = EX.is_load & EX.valid_wr` and any used, non-R15 source equals `EX.rd`.
- While stall is asserted: `pc_le=0`, `ifid_le=0`, `nop_sel=1`.
- While stall is asserted, forwarding selects are don't-care and are driven to 00.
- The stall lasts exactly one cycle. On the next cycle the load is in MEM and is forwarded with select 10.

Branch flush:
- When `branch_taken` is high and stall is low: `ifid_flush=1` for that cycle. `pc_le` and `ifid_le` stay 1.
- Stall and `branch_taken` both high: stall wins and `ifid_flush=0`. The branch is re-evaluated on the following cycle.

Counters:
- `stall_cnt` increments on every stall cycle; `flush_cnt` increments on every flush cycle.
- Both saturate at all-ones and do not wrap.

Default outputs: `pc_le=1`, `ifid_le=1`, `nop_sel=0`, `ifid_flush=0`, `fwd_*=00`.

## Timing
- Forwarding, stall and flush outputs are combinational from the ID inputs and the registered slots, and are valid in the same cycle as the inputs.
- No extra latency is added.
- Slots and counters update on the rising edge of `clk`.

While `reset`=1:
- All slots are cleared (`valid_wr=0`, `is_load=0`, `rd=0`) and both counters are cleared at the edge.
- Outputs are forced to `pc_le=1`, `ifid_le=1`, `nop_sel=1`, `ifid_flush=0`, `fwd_*=00`.

Reset during a stall:
- The stall is abandoned and the slots clear.
- The first cycle after reset deasserts has no hazards.

## Structure
Shared package `pipe_pkg`:
- forwarding select constants `FWD_RF`, `FWD_EX`, `FWD_MEM`, `FWD_WB`;
- `REG_W=4`;
- `R15=4'hF`;
- the stage-slot struct type.

Sub-module `hazard_scoreboard`:
- The three-slot shift register plus its bubble insertion.
- Instantiated once.
- Comparators, priority logic and counters stay in the top.

## Test plan
1. **ALU back-to-back.** I1 writes R3 (`rf_en`=1, not a load); next cycle ID reads Rn=R3. Required: `fwd_a=01`, no stall. One cycle later, a read of R3 gives `fwd_a=10`. Two cycles later, `fwd_a=11`.
2. **Load-use.** A load to R5 sits in EX; ID reads Rm=R5. Required: exactly one cycle of `pc_le=0`, `ifid_le=0`, `nop_sel=1`, then `fwd_b=10` and `stall_cnt=1`.
3. **Priority and R15.** EX and MEM both write R2; ID reads Rn=R2 and Rm=R15. Required: `fwd_a=01`, `fwd_b=00`.
4. **Branch flush.** `branch_taken=1` with no hazard. Required: `ifid_flush=1` for one cycle, `pc_le=1`, `flush_cnt` increments. With a simultaneous load-use hazard: `ifid_flush=0`, stall asserted, and the flush follows on the next cycle.
5. **Reset mid-stall.** Assert `reset` in the stall cycle. Required next cycle: all `fwd`=00, `nop_sel=1` while in reset, counters 0. After release there is no stall until a new load enters EX.
6. **Saturation.** With `CNT_W=2`, force 5 stalls. Required: `stall_cnt` ends at 3.
